// File: rtl/eth_f_hw_avmm_cmd_fanout_if.sv
// rtl/eth_f_hw_avmm_cmd_fanout_if.sv - host/client AVMM bus bundle for the command fanout
interface eth_f_hw_avmm_cmd_fanout_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DAT_WIDTH   = 32,
    parameter int NUM_CLIENTS = 2
);
    logic [ADDR_WIDTH-1:0]  host_address;
    logic                   host_read;
    logic                   host_write;
    logic [DAT_WIDTH-1:0]   host_writedata;
    logic                   host_waitrequest;
    logic                   rd_done;
    logic [ADDR_WIDTH-1:0]  client_address;
    logic [DAT_WIDTH-1:0]   client_writedata;
    logic [NUM_CLIENTS-1:0] client_read;
    logic [NUM_CLIENTS-1:0] client_write;
    logic [NUM_CLIENTS-1:0] client_waitrequest;
    logic                   cmd_timeout;
    logic                   unmapped_err;

    modport slave (
        input  host_address, host_read, host_write, host_writedata, rd_done, client_waitrequest,
        output host_waitrequest, client_address, client_writedata, client_read, client_write,
               cmd_timeout, unmapped_err
    );

    modport master (
        output host_address, host_read, host_write, host_writedata, rd_done, client_waitrequest,
        input  host_waitrequest, client_address, client_writedata, client_read, client_write,
               cmd_timeout, unmapped_err
    );
endinterface

// File: rtl/eth_f_hw_avmm_cmd_fanout.sv
// rtl/eth_f_hw_avmm_cmd_fanout.sv - splits one host AVMM command onto a decoded client
// One command in flight; the host is held off until the client accepts and, for reads, rd_done returns.
module eth_f_hw_avmm_cmd_fanout #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DAT_WIDTH        = 32,
    parameter int NUM_CLIENTS      = 2,
    parameter int CLIENT_ADDR_BITS = 12,
    parameter int TIMEOUT          = 8
) (
    input  logic                          clk,
    input  logic                          arst,
    eth_f_hw_avmm_cmd_fanout_if.slave     bus
);
    localparam int IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int HI_LSB = CLIENT_ADDR_BITS + IDX_W;
    localparam logic [IDX_W:0] NUM_CLIENTS_V = (IDX_W + 1)'(NUM_CLIENTS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;

    logic [1:0]             state;
    logic [TIMEOUT:0]       timer;
    logic                   cmd_is_read;
    logic [IDX_W-1:0]       idx;
    logic                   upper_zero;
    logic                   mapped;
    logic [NUM_CLIENTS-1:0] sel;
    logic                   host_req;
    logic                   client_accept;
    logic                   expired;

    assign idx = bus.host_address[CLIENT_ADDR_BITS +: IDX_W];

    generate
        if (HI_LSB < ADDR_WIDTH) begin : g_upper
            assign upper_zero = (bus.host_address[ADDR_WIDTH-1:HI_LSB] == '0);
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    assign mapped   = upper_zero && ({1'b0, idx} < NUM_CLIENTS_V);
    assign sel      = NUM_CLIENTS'(1) << idx;
    assign host_req = bus.host_read | bus.host_write;

    // Only the selected client's strobe is ever high, so masking finds its handshake.
    assign client_accept = |((bus.client_read | bus.client_write) & ~bus.client_waitrequest);
    assign expired       = timer[TIMEOUT];

    assign bus.host_waitrequest = arst | (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (arst) begin
            state                <= ST_IDLE;
            timer                <= '0;
            cmd_is_read          <= 1'b0;
            bus.client_address   <= '0;
            bus.client_writedata <= '0;
            bus.client_read      <= '0;
            bus.client_write     <= '0;
            bus.cmd_timeout      <= 1'b0;
            bus.unmapped_err     <= 1'b0;
        end else begin
            bus.cmd_timeout  <= 1'b0;
            bus.unmapped_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (host_req) begin
                        timer                <= '0;
                        bus.client_address   <= bus.host_address;
                        bus.client_writedata <= bus.host_writedata;
                        // A simultaneous read and write is treated as a read.
                        cmd_is_read          <= bus.host_read;
                        if (mapped) begin
                            if (bus.host_read) begin
                                bus.client_read <= sel;
                            end else begin
                                bus.client_write <= sel;
                            end
                            state <= ST_ISSUE;
                        end else begin
                            bus.unmapped_err <= 1'b1;
                            state <= bus.host_read ? ST_RD_WAIT : ST_IDLE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (client_accept) begin
                        bus.client_read  <= '0;
                        bus.client_write <= '0;
                        timer            <= timer + 1'b1;
                        state            <= cmd_is_read ? ST_RD_WAIT : ST_IDLE;
                    end else if (expired) begin
                        bus.client_read  <= '0;
                        bus.client_write <= '0;
                        bus.cmd_timeout  <= 1'b1;
                        state            <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    // Timer keeps running from the issue phase; the combine's own
                    // shorter timeout normally produces rd_done before this expires.
                    if (bus.rd_done) begin
                        state <= ST_IDLE;
                    end else if (expired) begin
                        bus.cmd_timeout <= 1'b1;
                        state           <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    bus.client_read  <= '0;
                    bus.client_write <= '0;
                    state            <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_eth_f_hw_avmm_cmd_fanout.sv
// tb/tb_eth_f_hw_avmm_cmd_fanout.sv - self-checking bench for the AVMM command fanout
module tb_eth_f_hw_avmm_cmd_fanout;
    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    eth_f_hw_avmm_cmd_fanout_if #(.ADDR_WIDTH(16), .DAT_WIDTH(32), .NUM_CLIENTS(2)) bus ();

    eth_f_hw_avmm_cmd_fanout #(
        .ADDR_WIDTH(16), .DAT_WIDTH(32), .NUM_CLIENTS(2), .CLIENT_ADDR_BITS(12), .TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    typedef struct packed {
        logic        rd;
        logic [1:0]  oh;
        logic [15:0] addr;
        logic [31:0] data;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t obs_q[$];
    int   errors = 0;
    int   checks = 0;

    // Records the first cycle of every client strobe.
    logic [1:0] prev_strobe = 2'b00;
    always @(negedge clk) begin
        cmd_t o;
        logic [1:0] cur;
        cur = bus.client_read | bus.client_write;
        if (cur != 2'b00 && prev_strobe == 2'b00) begin
            o.rd   = |bus.client_read;
            o.oh   = cur;
            o.addr = bus.client_address;
            o.data = bus.client_writedata;
            obs_q.push_back(o);
        end
        prev_strobe = cur;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a command during the current cycle (N); returns at the start of N+1.
    task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [31:0] data, input logic mapped_exp, input logic [1:0] oh);
        cmd_t e;
        bus.host_read      = rd;
        bus.host_write     = wr;
        bus.host_address   = addr;
        bus.host_writedata = data;
        if (mapped_exp) begin
            e.rd = rd; e.oh = oh; e.addr = addr; e.data = data;
            exp_q.push_back(e);
        end
        next_cycle();
        bus.host_read  = 1'b0;
        bus.host_write = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        bus.host_read = 0; bus.host_write = 0; bus.host_address = 0; bus.host_writedata = 0;
        bus.rd_done = 0; bus.client_waitrequest = 2'b00;
        next_cycle(); next_cycle();
        @(negedge clk);
        checks++; if (bus.host_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitreq: got %b expected 1", bus.host_waitrequest); end
        checks++; if ({bus.client_read, bus.client_write} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {bus.client_read, bus.client_write}); end
        checks++; if ({bus.cmd_timeout, bus.unmapped_err} !== 2'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {bus.cmd_timeout, bus.unmapped_err}); end
        checks++; if ({bus.client_address, bus.client_writedata} !== 48'h0) begin errors++; $display("FAIL reset_capture: got %h expected 0", {bus.client_address, bus.client_writedata}); end
        next_cycle();
        arst = 1'b0;
        @(negedge clk);
        checks++; if (bus.host_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_release_waitreq: got %b expected 0", bus.host_waitrequest); end
        next_cycle();
    endtask

    task automatic test_write_zero_stall();
        bus.client_waitrequest = 2'b00;
        issue(1'b0, 1'b1, 16'h1004, 32'hCAFE0001, 1'b1, 2'b10);
        @(negedge clk);
        checks++; if (bus.client_write !== 2'b10 || bus.client_read !== 2'b00) begin errors++; $display("FAIL wr_strobe_n1: got wr=%b rd=%b expected wr=10 rd=00", bus.client_write, bus.client_read); end
        checks++; if (bus.client_address !== 16'h1004) begin errors++; $display("FAIL wr_address: got %h expected 1004", bus.client_address); end
        checks++; if (bus.host_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_waitreq_n1: got %b expected 1", bus.host_waitrequest); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.client_write !== 2'b00) begin errors++; $display("FAIL wr_strobe_n2: got %b expected 00", bus.client_write); end
        checks++; if (bus.host_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_waitreq_n2: got %b expected 0", bus.host_waitrequest); end
        next_cycle();
    endtask

    task automatic test_read_stall();
        bus.client_waitrequest = 2'b01;
        issue(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 2'b01);
        for (int k = 1; k <= 10; k++) begin
            bus.client_waitrequest = (k <= 3) ? 2'b01 : 2'b00;
            bus.rd_done = (k == 9);
            @(negedge clk);
            checks++; if (bus.client_read !== ((k <= 4) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL rd_strobe k=%0d: got %b expected %b", k, bus.client_read, (k <= 4) ? 2'b01 : 2'b00); end
            checks++; if (bus.host_waitrequest !== (k <= 9)) begin errors++; $display("FAIL rd_waitreq k=%0d: got %b expected %b", k, bus.host_waitrequest, (k <= 9)); end
            next_cycle();
        end
        bus.rd_done = 1'b0;
    endtask

    task automatic test_unmapped();
        issue(1'b0, 1'b1, 16'h2000, 32'h12345678, 1'b0, 2'b00);
        @(negedge clk);
        checks++; if (bus.unmapped_err !== 1'b1) begin errors++; $display("FAIL unmap_wr_err: got %b expected 1", bus.unmapped_err); end
        checks++; if ({bus.client_read, bus.client_write} !== 4'b0) begin errors++; $display("FAIL unmap_wr_strobe: got %b expected 0000", {bus.client_read, bus.client_write}); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.unmapped_err !== 1'b0 || bus.host_waitrequest !== 1'b0) begin errors++; $display("FAIL unmap_wr_n2: got err=%b waitreq=%b expected 0 0", bus.unmapped_err, bus.host_waitrequest); end
        next_cycle();
        issue(1'b1, 1'b0, 16'h8000, 32'h0, 1'b0, 2'b00);
        for (int k = 1; k <= 6; k++) begin
            bus.rd_done = (k == 5);
            @(negedge clk);
            checks++; if (bus.unmapped_err !== (k == 1)) begin errors++; $display("FAIL unmap_rd_err k=%0d: got %b expected %b", k, bus.unmapped_err, (k == 1)); end
            checks++; if (bus.host_waitrequest !== (k <= 5)) begin errors++; $display("FAIL unmap_rd_waitreq k=%0d: got %b expected %b", k, bus.host_waitrequest, (k <= 5)); end
            checks++; if ({bus.client_read, bus.client_write, bus.cmd_timeout} !== 5'b0) begin errors++; $display("FAIL unmap_rd_quiet k=%0d: got %b expected 00000", k, {bus.client_read, bus.client_write, bus.cmd_timeout}); end
            next_cycle();
        end
        bus.rd_done = 1'b0;
    endtask

    task automatic test_timeout();
        bus.client_waitrequest = 2'b11;
        issue(1'b0, 1'b1, 16'h0008, 32'hDEAD0008, 1'b1, 2'b01);
        for (int k = 1; k <= 259; k++) begin
            @(negedge clk);
            checks++; if (bus.client_write !== ((k <= 257) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL to_strobe k=%0d: got %b expected %b", k, bus.client_write, (k <= 257) ? 2'b01 : 2'b00); end
            checks++; if (bus.cmd_timeout !== (k == 258)) begin errors++; $display("FAIL to_pulse k=%0d: got %b expected %b", k, bus.cmd_timeout, (k == 258)); end
            checks++; if (bus.host_waitrequest !== (k < 258)) begin errors++; $display("FAIL to_waitreq k=%0d: got %b expected %b", k, bus.host_waitrequest, (k < 258)); end
            next_cycle();
        end
        bus.client_waitrequest = 2'b00;
    endtask

    task automatic test_read_write_both();
        bus.client_waitrequest = 2'b00;
        issue(1'b1, 1'b1, 16'h0000, 32'h55AA55AA, 1'b1, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            bus.rd_done = (k == 2);
            @(negedge clk);
            checks++; if (bus.client_read !== ((k == 1) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL both_rd k=%0d: got %b expected %b", k, bus.client_read, (k == 1) ? 2'b01 : 2'b00); end
            checks++; if (bus.client_write !== 2'b00) begin errors++; $display("FAIL both_wr k=%0d: got %b expected 00", k, bus.client_write); end
            checks++; if (bus.host_waitrequest !== (k <= 2)) begin errors++; $display("FAIL both_waitreq k=%0d: got %b expected %b", k, bus.host_waitrequest, (k <= 2)); end
            next_cycle();
        end
        bus.rd_done = 1'b0;
    endtask

    task automatic test_reset_mid_command();
        bus.client_waitrequest = 2'b11;
        issue(1'b0, 1'b1, 16'h1010, 32'hABCD0010, 1'b1, 2'b10);
        for (int k = 1; k <= 8; k++) begin
            arst = (k == 3);
            @(negedge clk);
            checks++; if (bus.client_write !== ((k <= 3) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL mid_rst_strobe k=%0d: got %b expected %b", k, bus.client_write, (k <= 3) ? 2'b10 : 2'b00); end
            checks++; if ({bus.cmd_timeout, bus.unmapped_err} !== 2'b00) begin errors++; $display("FAIL mid_rst_pulses k=%0d: got %b expected 00", k, {bus.cmd_timeout, bus.unmapped_err}); end
            checks++; if (bus.host_waitrequest !== (k <= 3)) begin errors++; $display("FAIL mid_rst_waitreq k=%0d: got %b expected %b", k, bus.host_waitrequest, (k <= 3)); end
            if (k == 4) begin
                checks++; if (bus.client_address !== 16'h0) begin errors++; $display("FAIL mid_rst_addr: got %h expected 0000", bus.client_address); end
            end
            next_cycle();
        end
        arst = 1'b0;
        bus.client_waitrequest = 2'b00;
        issue(1'b1, 1'b0, 16'h1020, 32'h0, 1'b1, 2'b10);
        for (int k = 1; k <= 4; k++) begin
            bus.rd_done = (k == 3);
            @(negedge clk);
            checks++; if (bus.client_read !== ((k == 1) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL post_rst_rd k=%0d: got %b expected %b", k, bus.client_read, (k == 1) ? 2'b10 : 2'b00); end
            checks++; if (bus.host_waitrequest !== (k <= 3)) begin errors++; $display("FAIL post_rst_waitreq k=%0d: got %b expected %b", k, bus.host_waitrequest, (k <= 3)); end
            next_cycle();
        end
        bus.rd_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic        ci;
        bus.client_waitrequest = 2'b00;
        for (int i = 0; i < 8; i++) begin
            ci = 1'($urandom_range(0, 1));
            a  = {3'b000, ci, 12'($urandom)};
            issue(1'b0, 1'b1, a, $urandom, 1'b1, ci ? 2'b10 : 2'b01);
            next_cycle();
        end
        next_cycle();
    endtask

    task automatic test_scoreboard();
        cmd_t e;
        cmd_t o;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL sb_missing: got no strobe expected rd=%0b oh=%b addr=%h data=%h", e.rd, e.oh, e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL sb_cmd: got rd=%0b oh=%b addr=%h data=%h expected rd=%0b oh=%b addr=%h data=%h",
                             o.rd, o.oh, o.addr, o.data, e.rd, e.oh, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL sb_extra: got %0d unexpected strobes expected 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_stall();
        test_read_stall();
        test_unmapped();
        test_timeout();
        test_read_write_both();
        test_reset_mid_command();
        test_back_to_back();
        test_scoreboard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
